// File: rtl/z16_data_mem_responder.sv
// Z16 data-memory responder: accepts one CPU load/store at a time and answers
// with a single-cycle ack after LATENCY wait cycles, flagging misaligned or out-of-range accesses.
module z16_data_mem_responder #(
    parameter int LATENCY     = 2,
    parameter int DEPTH_WORDS = 128
) (
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic        i_req,
    input  logic        i_wen,
    input  logic [15:0] i_addr,
    input  logic [15:0] i_wdata,
    output logic        o_ready,
    output logic        o_ack,
    output logic [15:0] o_rdata,
    output logic        o_err
);
    localparam int IDX_W = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] WAIT = 2'd1;
    localparam logic [1:0] RESP = 2'd2;

    localparam logic [3:0] WAIT_LOAD = (LATENCY > 0) ? 4'(LATENCY - 1) : 4'd0;

    logic [1:0]  state;
    logic [3:0]  wait_cnt;
    logic        lat_wen;
    logic [15:0] lat_addr;
    logic [15:0] lat_wdata;
    logic        ack;
    logic        err;
    logic [15:0] rdata;

    logic [15:0] mem [DEPTH_WORDS];

    logic             accept;
    logic             commit;
    logic             txn_wen;
    logic [15:0]      txn_addr;
    logic [15:0]      txn_wdata;
    logic [IDX_W-1:0] txn_idx;
    logic             fault;
    logic             do_write;

    assign accept = (state == IDLE) && i_req;

    // With zero latency the access commits on the accepting edge, so it works from the live inputs
    assign commit    = (LATENCY == 0) ? accept : ((state == WAIT) && (wait_cnt == 4'd0));
    assign txn_wen   = (state == IDLE) ? i_wen   : lat_wen;
    assign txn_addr  = (state == IDLE) ? i_addr  : lat_addr;
    assign txn_wdata = (state == IDLE) ? i_wdata : lat_wdata;
    assign txn_idx   = txn_addr[IDX_W:1];
    assign fault     = txn_addr[0] || ({17'd0, txn_addr[15:1]} >= 32'(DEPTH_WORDS));
    assign do_write  = i_rst_n && commit && !fault && txn_wen;

    // Storage is deliberately outside reset so a reset never disturbs its contents
    always_ff @(posedge i_clk) begin
        if (do_write) begin
            mem[txn_idx] <= txn_wdata;
        end
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            state     <= IDLE;
            wait_cnt  <= 4'd0;
            ack       <= 1'b0;
            err       <= 1'b0;
            rdata     <= 16'd0;
            lat_wen   <= 1'b0;
            lat_addr  <= 16'd0;
            lat_wdata <= 16'd0;
        end else begin
            ack   <= 1'b0;
            err   <= 1'b0;
            rdata <= 16'd0;
            case (state)
                IDLE: begin
                    if (i_req) begin
                        lat_wen   <= i_wen;
                        lat_addr  <= i_addr;
                        lat_wdata <= i_wdata;
                        if (LATENCY == 0) begin
                            state <= RESP;
                        end else begin
                            state    <= WAIT;
                            wait_cnt <= WAIT_LOAD;
                        end
                    end
                end
                WAIT: begin
                    if (wait_cnt == 4'd0) begin
                        state <= RESP;
                    end else begin
                        wait_cnt <= wait_cnt - 4'd1;
                    end
                end
                RESP:    state <= IDLE;
                default: state <= IDLE;
            endcase
            if (commit) begin
                ack <= 1'b1;
                err <= fault;
                if (!fault && !txn_wen) begin
                    rdata <= mem[txn_idx];
                end
            end
        end
    end

    assign o_ready = (state == IDLE);
    assign o_ack   = ack;
    assign o_err   = err;
    assign o_rdata = rdata;

endmodule
